// File: rtl/hazard_match_pipe.sv
// Shadow copies of the E/M/W pipeline registers that feed the hazard unit with
// register-address matches, condition-qualified write enables and PC-write tracking.
module hazard_match_pipe #(
  parameter int              RW     = 4,
  parameter logic [RW-1:0]   PC_REG = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ValidD,
  input  logic [RW-1:0] RA1D,
  input  logic [RW-1:0] RA2D,
  input  logic [RW-1:0] WA3D,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          PCSrcD,
  input  logic          BranchD,
  input  logic          CondExE,
  input  logic          FlushE,
  output logic          Match_1E_M,
  output logic          Match_1E_W,
  output logic          Match_2E_M,
  output logic          Match_2E_W,
  output logic          Match_12D_E,
  output logic          RegWriteM,
  output logic          RegWriteW,
  output logic          MemtoRegE,
  output logic          BranchTakenE,
  output logic          PCWrPendingF,
  output logic          PCSrcW
);

  logic          validE, regWriteE, memtoRegE, pcSrcE, branchE;
  logic [RW-1:0] ra1E, ra2E, wa3E;
  logic          validM, regWriteM, pcSrcM;
  logic [RW-1:0] wa3M;
  logic          validW, regWriteW, pcSrcW;
  logic [RW-1:0] wa3W;

  // R15 reads PC+8 from the datapath and is never forwarded, so it never matches.
  function automatic logic srcHit(input logic [RW-1:0] src, input logic [RW-1:0] dst);
    return (src == dst) && (src != PC_REG);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validE    <= 1'b0;
      ra1E      <= '0;
      ra2E      <= '0;
      wa3E      <= '0;
      regWriteE <= 1'b0;
      memtoRegE <= 1'b0;
      pcSrcE    <= 1'b0;
      branchE   <= 1'b0;
      validM    <= 1'b0;
      wa3M      <= '0;
      regWriteM <= 1'b0;
      pcSrcM    <= 1'b0;
      validW    <= 1'b0;
      wa3W      <= '0;
      regWriteW <= 1'b0;
      pcSrcW    <= 1'b0;
    end else begin
      // A flush overrides whatever decode presents; control bits are killed for bubbles.
      if (FlushE) begin
        validE    <= 1'b0;
        ra1E      <= '0;
        ra2E      <= '0;
        wa3E      <= '0;
        regWriteE <= 1'b0;
        memtoRegE <= 1'b0;
        pcSrcE    <= 1'b0;
        branchE   <= 1'b0;
      end else begin
        validE    <= ValidD;
        ra1E      <= RA1D;
        ra2E      <= RA2D;
        wa3E      <= WA3D;
        regWriteE <= RegWriteD & ValidD;
        memtoRegE <= MemtoRegD & ValidD;
        pcSrcE    <= PCSrcD & ValidD;
        branchE   <= BranchD & ValidD;
      end
      // A condition-failed instruction keeps flowing but loses its side effects.
      validM    <= validE;
      wa3M      <= wa3E;
      regWriteM <= regWriteE & CondExE;
      pcSrcM    <= pcSrcE & CondExE;
      validW    <= validM;
      wa3W      <= wa3M;
      regWriteW <= regWriteM;
      pcSrcW    <= pcSrcM;
    end
  end

  assign Match_1E_M  = validE & validM & srcHit(ra1E, wa3M);
  assign Match_1E_W  = validE & validW & srcHit(ra1E, wa3W);
  assign Match_2E_M  = validE & validM & srcHit(ra2E, wa3M);
  assign Match_2E_W  = validE & validW & srcHit(ra2E, wa3W);
  assign Match_12D_E = ValidD & validE & (srcHit(RA1D, wa3E) | srcHit(RA2D, wa3E));

  assign RegWriteM    = regWriteM;
  assign RegWriteW    = regWriteW;
  assign MemtoRegE    = memtoRegE & validE;
  assign BranchTakenE = branchE & CondExE & validE;
  assign PCWrPendingF = (ValidD & PCSrcD) | pcSrcE | pcSrcM;
  assign PCSrcW       = pcSrcW;

endmodule
